// File: rtl/sqrt_unsigned_pipe.sv
// Unsigned fixed-point square root, non-restoring digit recurrence, one result bit per stage; SQRT_ROUND_EN adds a round stage.
// Latency: N+2 cycles with N = IN_W/2+FRAC_W (+1 with SQRT_ROUND_EN); one sample per cycle.
// Backpressure: a single global enable freezes every stage while valid_out is held and ready_in is low.
module sqrt_unsigned_pipe #(
    parameter int IN_W   = 20,
    parameter int FRAC_W = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  logic [IN_W-1:0]         x,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic [IN_W/2+FRAC_W-1:0] y,
    output logic                    exact
);

    localparam int RES_W = IN_W/2 + FRAC_W;
`ifdef SQRT_ROUND_EN
    localparam int N = RES_W + 1;
`else
    localparam int N = RES_W;
`endif
    localparam int RAD_W = 2*N;
    localparam int REM_W = N + 2;
    localparam int SH    = 2*(N - IN_W/2);

    logic en;
    assign en        = !valid_out || ready_in;
    assign ready_out = en;

    logic [N:0]       vld_q;
    logic [RAD_W-1:0] rad_q [0:N-1];
    logic [REM_W-1:0] rem_q [0:N];
    logic [N-1:0]     quo_q [0:N];

    logic [REM_W-1:0] rem_nxt [1:N];
    logic [N-1:0]     quo_nxt [1:N];

    // Non-negative remainder subtracts 4Q+1, negative one adds 4Q+3.
    function automatic logic [REM_W-1:0] iter_rem(
        input logic [REM_W-1:0] r,
        input logic [N-1:0]     q,
        input logic [1:0]       d
    );
        logic [REM_W-1:0] sh;
        sh = REM_W'({r, d});
        if (r[REM_W-1])
            iter_rem = sh + {q, 2'b11};
        else
            iter_rem = sh - {q, 2'b01};
    endfunction

    always_comb begin
        for (int k = 1; k <= N; k++) begin
            rem_nxt[k] = iter_rem(rem_q[k-1], quo_q[k-1], rad_q[k-1][RAD_W-1 -: 2]);
            quo_nxt[k] = N'({quo_q[k-1], ~rem_nxt[k][REM_W-1]});
        end
    end

    logic [REM_W-1:0] rem_fix;
    logic [N-1:0]     q_fin;
    logic [RES_W-1:0] y_nxt;
    logic             exact_nxt;
`ifdef SQRT_ROUND_EN
    logic [RES_W:0]   rnd_sum;
`endif

    always_comb begin
        q_fin   = quo_q[N];
        rem_fix = rem_q[N];
        if (rem_q[N][REM_W-1])
            rem_fix = rem_q[N] + {1'b0, q_fin, 1'b1};
`ifdef SQRT_ROUND_EN
        rnd_sum   = {1'b0, q_fin[N-1:1]} + {{RES_W{1'b0}}, q_fin[0]};
        y_nxt     = rnd_sum[RES_W] ? {RES_W{1'b1}} : rnd_sum[RES_W-1:0];
        exact_nxt = (rem_fix == '0) && !q_fin[0];
`else
        y_nxt     = q_fin;
        exact_nxt = (rem_fix == '0);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            valid_out <= 1'b0;
            y         <= '0;
            exact     <= 1'b0;
            for (int k = 0; k < N; k++)
                rad_q[k] <= '0;
            for (int k = 0; k <= N; k++) begin
                rem_q[k] <= '0;
                quo_q[k] <= '0;
            end
        end else if (en) begin
            vld_q[0] <= valid_in;
            rad_q[0] <= RAD_W'(x) << SH;
            rem_q[0] <= '0;
            quo_q[0] <= '0;
            for (int k = 1; k < N; k++)
                rad_q[k] <= rad_q[k-1] << 2;
            for (int k = 1; k <= N; k++) begin
                vld_q[k] <= vld_q[k-1];
                rem_q[k] <= rem_nxt[k];
                quo_q[k] <= quo_nxt[k];
            end
            valid_out <= vld_q[N];
            y         <= y_nxt;
            exact     <= exact_nxt;
        end
    end

endmodule
